// File: rtl/fetch_block_splitter.sv
// rtl/fetch_block_splitter.sv - serialises a 4-instruction fetch block into one instruction per cycle
// Optional feature macro: SPLITTER_SKIP_ZERO_FMT_EN (drop slots whose format vector is all-zero)
module fetch_block_splitter #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int formatWidth             = 25,
  parameter int PrimOpcodeSize          = 6,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               block_valid_i,
  output logic                               block_ready_o,
  input  logic [4*instructionWidth-1:0]      block_i,
  input  logic [4*formatWidth-1:0]           blockFormats_i,
  input  logic [addressWidth-1:0]            blockAddress_i,
  input  logic [1:0]                         startSlot_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic                               stall_i,
  input  logic                               flush_i,
  output logic                               enable_o,
  output logic [formatWidth-1:0]             instFormat_o,
  output logic [PrimOpcodeSize-1:0]          instructionOpcode_o,
  output logic [instructionWidth-1:0]        instruction_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instructionPid_o,
  output logic [TidSize-1:0]                 instructionTid_o,
  output logic [instructionCounterWidth-1:0] instructionMajId_o
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                               state, state_next;
  logic [1:0]                           slot;
  logic [4*instructionWidth-1:0]        blk_q;
  logic [4*formatWidth-1:0]             fmt_q;
  logic [addressWidth-1:0]              base_q;
  logic                                 is64_q;
  logic [PidSize-1:0]                   pid_q;
  logic [TidSize-1:0]                   tid_q;
  logic [instructionCounterWidth-1:0]   counter;
  logic [instructionWidth-1:0]          cur_inst;
  logic [formatWidth-1:0]               cur_fmt;
  logic                                 skip_slot;

  // Select the instruction and format of the current slot (slot 0 sits in the MSBs)
  always_comb begin
    cur_inst = blk_q[4*instructionWidth-1 -: instructionWidth];
    cur_fmt  = fmt_q[4*formatWidth-1 -: formatWidth];
    case (slot)
      2'd1: begin
        cur_inst = blk_q[3*instructionWidth-1 -: instructionWidth];
        cur_fmt  = fmt_q[3*formatWidth-1 -: formatWidth];
      end
      2'd2: begin
        cur_inst = blk_q[2*instructionWidth-1 -: instructionWidth];
        cur_fmt  = fmt_q[2*formatWidth-1 -: formatWidth];
      end
      2'd3: begin
        cur_inst = blk_q[instructionWidth-1 -: instructionWidth];
        cur_fmt  = fmt_q[formatWidth-1 -: formatWidth];
      end
      default: ;
    endcase
  end

  // Decide whether the current slot is silently consumed instead of emitted
  always_comb begin
`ifdef SPLITTER_SKIP_ZERO_FMT_EN
    skip_slot = (cur_fmt == '0);
`else
    skip_slot = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic: flush wins over stall, stall freezes everything
  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = IDLE;
    end else if (!stall_i) begin
      case (state)
        IDLE:    if (block_valid_i) state_next = EMIT;
        EMIT:    if (slot == 2'd3)  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Handshake output depends on state only
  always_comb begin
    block_ready_o = (state == IDLE) && !reset_i;
  end

  // Block capture, slot/ID bookkeeping and registered decoder outputs
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      slot                 <= '0;
      blk_q                <= '0;
      fmt_q                <= '0;
      base_q               <= '0;
      is64_q               <= 1'b0;
      pid_q                <= '0;
      tid_q                <= '0;
      counter              <= '0;
      enable_o             <= 1'b0;
      instFormat_o         <= '0;
      instructionOpcode_o  <= '0;
      instruction_o        <= '0;
      instructionAddress_o <= '0;
      is64Bit_o            <= 1'b0;
      instructionPid_o     <= '0;
      instructionTid_o     <= '0;
      instructionMajId_o   <= '0;
    end else if (flush_i) begin
      enable_o <= 1'b0;
    end else if (!stall_i) begin
      if (state == IDLE) begin
        enable_o <= 1'b0;
        if (block_valid_i) begin
          blk_q  <= block_i;
          fmt_q  <= blockFormats_i;
          base_q <= blockAddress_i & ~{{(addressWidth-4){1'b0}}, 4'hF};
          is64_q <= is64Bit_i;
          pid_q  <= instructionPid_i;
          tid_q  <= instructionTid_i;
          slot   <= startSlot_i;
        end
      end else begin
        slot <= slot + 2'd1;
        if (skip_slot) begin
          enable_o <= 1'b0;
        end else begin
          enable_o             <= 1'b1;
          instFormat_o         <= cur_fmt;
          instructionOpcode_o  <= cur_inst[PrimOpcodeSize-1:0];
          instruction_o        <= cur_inst;
          instructionAddress_o <= base_q + {{(addressWidth-4){1'b0}}, slot, 2'b00};
          is64Bit_o            <= is64_q;
          instructionPid_o     <= pid_q;
          instructionTid_o     <= tid_q;
          instructionMajId_o   <= counter;
          counter              <= counter + instructionCounterWidth'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_block_splitter.sv
// tb/tb_fetch_block_splitter.sv - directed self-checking bench for fetch_block_splitter
module tb_fetch_block_splitter;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          block_valid = 1'b0;
  logic          block_ready;
  logic [127:0]  block = '0;
  logic [99:0]   formats = '0;
  logic [63:0]   address = '0;
  logic [1:0]    start_slot = '0;
  logic          is64 = 1'b0;
  logic [19:0]   pid = '0;
  logic [15:0]   tid = '0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          enable;
  logic [24:0]   fmt_out;
  logic [5:0]    opcode;
  logic [31:0]   inst;
  logic [63:0]   inst_addr;
  logic          is64_out;
  logic [19:0]   pid_out;
  logic [15:0]   tid_out;
  logic [63:0]   maj_id;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_block_splitter dut (
    .clock_i(clk), .reset_i(rst),
    .block_valid_i(block_valid), .block_ready_o(block_ready),
    .block_i(block), .blockFormats_i(formats), .blockAddress_i(address),
    .startSlot_i(start_slot), .is64Bit_i(is64), .instructionPid_i(pid),
    .instructionTid_i(tid), .stall_i(stall), .flush_i(flush),
    .enable_o(enable), .instFormat_o(fmt_out), .instructionOpcode_o(opcode),
    .instruction_o(inst), .instructionAddress_o(inst_addr), .is64Bit_o(is64_out),
    .instructionPid_o(pid_out), .instructionTid_o(tid_out), .instructionMajId_o(maj_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [5:0] op_of(input int k);
    return (k % 2 == 0) ? 6'd59 : 6'd63;
  endfunction

  function automatic logic [31:0] mk_inst(input logic [7:0] tag, input int k);
    return {tag, 8'(k), 10'h0, op_of(k)};
  endfunction

  task automatic offer(input logic [7:0] tag, input logic [63:0] addr,
                       input logic [1:0] start, input logic [24:0] f1);
    block       = {mk_inst(tag, 0), mk_inst(tag, 1), mk_inst(tag, 2), mk_inst(tag, 3)};
    formats     = {25'h2, f1, 25'h2, 25'h2};
    address     = addr;
    start_slot  = start;
    block_valid = 1'b1;
  endtask

  task automatic expect_emit(input string tag, input logic [7:0] btag, input int k,
                             input logic [63:0] addr, input logic [63:0] id);
    check({tag, ".en"},   enable,    1);
    check({tag, ".addr"}, inst_addr, addr);
    check({tag, ".id"},   maj_id,    id);
    check({tag, ".op"},   opcode,    op_of(k));
    check({tag, ".inst"}, inst,      mk_inst(btag, k));
  endtask

  initial begin
    is64 = 1'b1; pid = 20'hABCDE; tid = 16'h1234;
    @(negedge clk);
    check("rst.en", enable, 0);
    check("rst.ready", block_ready, 0);
    check("rst.id", maj_id, 0);
    tick();
    rst = 1'b0;
    tick();
    check("idle.ready", block_ready, 1);

    // Reset while slot 1 is being presented
    offer(8'h11, 64'h9000, 2'd0, 25'h2);
    tick();
    block_valid = 1'b0;
    tick();
    tick();
    check("pre_rst.id", maj_id, 1);
    rst = 1'b1;
    #1;
    check("mid_rst.en", enable, 0);
    check("mid_rst.addr", inst_addr, 0);
    check("mid_rst.id", maj_id, 0);
    check("mid_rst.inst", inst, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst.ready", block_ready, 1);
    @(negedge clk);

    // Full block from slot 0
    offer(8'hA1, 64'h1000, 2'd0, 25'h2);
    tick();
    block_valid = 1'b0;
    check("b1.acc.ready", block_ready, 0);
    check("b1.acc.en", enable, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_emit($sformatf("b1.s%0d", k), 8'hA1, k, 64'h1000 + 64'(4 * k), 64'(k));
      check($sformatf("b1.s%0d.fmt", k), fmt_out, 25'h2);
      check($sformatf("b1.s%0d.ready", k), block_ready, (k == 3) ? 1 : 0);
    end
    check("b1.is64", is64_out, 1);
    check("b1.pid", pid_out, 20'hABCDE);
    check("b1.tid", tid_out, 16'h1234);

    // Block entered mid-way at slot 2, offered right after the previous one
    offer(8'hB2, 64'h2008, 2'd2, 25'h2);
    tick();
    block_valid = 1'b0;
    check("b2.acc.en", enable, 0);
    check("b2.acc.ready", block_ready, 0);
    tick();
    expect_emit("b2.s2", 8'hB2, 2, 64'h2008, 4);
    tick();
    expect_emit("b2.s3", 8'hB2, 3, 64'h200C, 5);
    check("b2.ready", block_ready, 1);
    tick();
    check("b2.done.en", enable, 0);

    // Stall held over slot 1, then flush+stall while slot 2 is presented
    offer(8'hC3, 64'h3000, 2'd0, 25'h2);
    tick();
    block_valid = 1'b0;
    tick();
    expect_emit("b3.s0", 8'hC3, 0, 64'h3000, 6);
    tick();
    expect_emit("b3.s1", 8'hC3, 1, 64'h3004, 7);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_emit($sformatf("b3.stall%0d", i), 8'hC3, 1, 64'h3004, 7);
    end
    stall = 1'b0;
    tick();
    expect_emit("b3.s2", 8'hC3, 2, 64'h3008, 8);
    flush = 1'b1; stall = 1'b1;
    tick();
    check("flush.en", enable, 0);
    check("flush.ready", block_ready, 1);
    flush = 1'b0; stall = 1'b0;
    tick();
    check("flush.no_s3", enable, 0);

    // Flush beats block acceptance; then a single-instruction block from slot 3
    offer(8'hD4, 64'h400F, 2'd3, 25'h2);
    flush = 1'b1;
    tick();
    check("flush_acc.ready", block_ready, 1);
    check("flush_acc.en", enable, 0);
    flush = 1'b0;
    tick();
    block_valid = 1'b0;
    check("b4.acc.ready", block_ready, 0);
    tick();
    expect_emit("b4.s3", 8'hD4, 3, 64'h400C, 9);
    check("b4.ready", block_ready, 1);
    tick();
    check("b4.done.en", enable, 0);

    // Slot 1 with an all-zero format vector
    offer(8'hE5, 64'h5000, 2'd0, 25'h0);
    tick();
    block_valid = 1'b0;
    tick();
    expect_emit("b5.s0", 8'hE5, 0, 64'h5000, 10);
`ifdef SPLITTER_SKIP_ZERO_FMT_EN
    tick();
    check("b5.gap.en", enable, 0);
    tick();
    expect_emit("b5.s2", 8'hE5, 2, 64'h5008, 11);
    tick();
    expect_emit("b5.s3", 8'hE5, 3, 64'h500C, 12);
`else
    tick();
    expect_emit("b5.s1", 8'hE5, 1, 64'h5004, 11);
    check("b5.s1.fmt", fmt_out, 0);
    tick();
    expect_emit("b5.s2", 8'hE5, 2, 64'h5008, 12);
    tick();
    expect_emit("b5.s3", 8'hE5, 3, 64'h500C, 13);
`endif
    check("b5.ready", block_ready, 1);
    tick();
    check("b5.done.en", enable, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
